// File: rtl/matrix_mem_arbiter.sv
// Two-requester round-robin arbiter sharing one synchronous-read memory, one access per cycle.
// Optional ownership locking is compiled in with `define MEM_ARB_LOCK_EN.
module matrix_mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_i,
    input  logic                  req1_i,
    input  logic                  we0_i,
    input  logic                  we1_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata0_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic                  lock0_i,
    input  logic                  lock1_i,
    output logic                  gnt0_o,
    output logic                  gnt1_o,
    output logic                  rvalid0_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [ADDR_WIDTH-1:0] mem_raddr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  owner_o
);

    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [1:0]            rv_pend_q, rv_pend_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  hold0, hold1;
    logic                  any_gnt, sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef MEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] MAX_LOCK_C = CNT_W'(MAX_LOCK);

    logic             lock_act_q, lock_act_d;
    logic             lock_own_q, lock_own_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d, cnt_next;
    logic             sel_lock;

    // The owner keeps winning only while it still asserts both req and lock.
    assign hold0 = lock_act_q && !lock_own_q && req0_i && lock0_i;
    assign hold1 = lock_act_q &&  lock_own_q && req1_i && lock1_i;
`else
    logic unused_lock;
    localparam int UNUSED_MAX_LOCK = MAX_LOCK;

    assign unused_lock = lock0_i ^ lock1_i;
    assign hold0       = 1'b0;
    assign hold1       = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        gnt0_o = 1'b0;
        gnt1_o = 1'b0;
        if (!rst) begin
            if (hold0) begin
                gnt0_o = 1'b1;
            end else if (hold1) begin
                gnt1_o = 1'b1;
            end else if (req0_i && req1_i) begin
                gnt0_o = last_q;
                gnt1_o = !last_q;
            end else begin
                gnt0_o = req0_i;
                gnt1_o = req1_i;
            end
        end
    end

    assign any_gnt   = gnt0_o | gnt1_o;
    assign sel_we    = gnt1_o ? we1_i    : we0_i;
    assign sel_addr  = gnt1_o ? addr1_i  : addr0_i;
    assign sel_wdata = gnt1_o ? wdata1_i : wdata0_i;

    // Memory ports follow the grant combinationally and otherwise hold their last value.
    always_comb begin
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        rv_pend_d = {gnt1_o & !we1_i, gnt0_o & !we0_i};
        last_d    = any_gnt ? gnt1_o : last_q;
        owner_d   = any_gnt ? gnt1_o : owner_q;
        if (any_gnt && sel_we) begin
            waddr_d = sel_addr;
            wdata_d = sel_wdata;
        end else if (any_gnt) begin
            raddr_d = sel_addr;
        end
    end

    assign mem_we_o    = any_gnt & sel_we;
    assign mem_waddr_o = waddr_d;
    assign mem_wdata_o = wdata_d;
    assign mem_raddr_o = raddr_d;
    assign rvalid0_o   = rv_pend_q[0];
    assign rvalid1_o   = rv_pend_q[1];
    assign rdata0_o    = mem_rdata_i;
    assign rdata1_o    = mem_rdata_i;
    assign owner_o     = owner_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            rv_pend_q <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
        end else begin
            last_q    <= last_d;
            owner_q   <= owner_d;
            rv_pend_q <= rv_pend_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    assign sel_lock = gnt1_o ? lock1_i : lock0_i;
    assign cnt_next = (lock_act_q && lock_own_q == gnt1_o) ? lock_cnt_q + 1'b1 : CNT_W'(1);

    // Acquiring grant counts as the first locked grant; reaching MAX_LOCK forces release.
    always_comb begin
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        if (lock_act_q && !(hold0 || hold1)) begin
            lock_act_d = 1'b0;
            lock_cnt_d = '0;
        end
        if (any_gnt) begin
            if (sel_lock && cnt_next < MAX_LOCK_C) begin
                lock_act_d = 1'b1;
                lock_own_d = gnt1_o;
                lock_cnt_d = cnt_next;
            end else begin
                lock_act_d = 1'b0;
                lock_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_act_q <= 1'b0;
            lock_own_q <= 1'b0;
            lock_cnt_q <= '0;
        end else begin
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Directed bench for matrix_mem_arbiter: bench-side memory model plus a read scoreboard.
// Lock expectations follow `MEM_ARB_LOCK_EN` with MAX_LOCK = 4.
module tb_matrix_mem_arbiter;

    typedef struct {
        logic       id;
        logic [7:0] data;
    } rd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1, mem_we, owner;
    logic [7:0] rdata0, rdata1, mem_waddr, mem_wdata, mem_raddr, mem_rdata;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    rd_t        sb [$];
    logic [1:0] exp_rv;
    logic       exp_owner;
    logic [7:0] exp_raddr, exp_waddr, exp_wdata;
    int         tests  = 0;
    int         failed = 0;

    matrix_mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_LOCK(4)) dut (
        .clk(clk), .rst(rst),
        .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .lock0_i(lock0), .lock1_i(lock1),
        .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
        .rdata0_o(rdata0), .rdata1_o(rdata1),
        .mem_we_o(mem_we), .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata),
        .mem_raddr_o(mem_raddr), .mem_rdata_i(mem_rdata), .owner_o(owner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt0"}, gnt0, 1'b0);
        check({tag, "_gnt1"}, gnt1, 1'b0);
        check({tag, "_rvalid"}, {rvalid1, rvalid0}, 2'b00);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_addrs"}, {mem_waddr, mem_raddr, mem_wdata}, 24'h0);
        check({tag, "_owner"}, owner, 1'b0);
    endtask

    // One clock cycle: drive at the falling edge, check outputs 1 time unit later.
    task automatic step(input logic r0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic [7:0] a1, input logic [7:0] d1,
                        input logic l0, input logic l1, input logic eg0, input logic eg1,
                        input string tag);
        rd_t exp_rd;
        logic g_we;
        logic [7:0] g_addr, g_data;
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
        #1;
        check({tag, "_rvalid0"}, rvalid0, exp_rv[0]);
        check({tag, "_rvalid1"}, rvalid1, exp_rv[1]);
        if (exp_rv != 2'b00) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 1'b1, 1'b0);
            end else begin
                exp_rd = sb.pop_front();
                check({tag, "_rdata"}, exp_rd.id ? rdata1 : rdata0, exp_rd.data);
            end
        end
        check({tag, "_gnt0"}, gnt0, eg0);
        check({tag, "_gnt1"}, gnt1, eg1);
        check({tag, "_excl"}, gnt0 & gnt1, 1'b0);
        check({tag, "_owner"}, owner, exp_owner);
        exp_rv = 2'b00;
        if (eg0 || eg1) begin
            g_we   = eg1 ? w1 : w0;
            g_addr = eg1 ? a1 : a0;
            g_data = eg1 ? d1 : d0;
            exp_owner = eg1;
            if (g_we) begin
                exp_waddr = g_addr;
                exp_wdata = g_data;
                ref_mem[g_addr] = g_data;
            end else begin
                exp_raddr = g_addr;
                exp_rd.id = eg1;
                exp_rd.data = ref_mem[g_addr];
                sb.push_back(exp_rd);
                exp_rv = eg1 ? 2'b10 : 2'b01;
            end
        end else begin
            g_we = 1'b0;
        end
        check({tag, "_mem_we"}, mem_we, g_we);
        check({tag, "_raddr"}, mem_raddr, exp_raddr);
        check({tag, "_waddr"}, mem_waddr, exp_waddr);
        check({tag, "_wdata"}, mem_wdata, exp_wdata);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i * 3 + 1);
            ref_mem[i] = 8'(i * 3 + 1);
        end
        mem[8'h10]     = 8'h5A;
        ref_mem[8'h10] = 8'h5A;
        exp_rv = 2'b00; exp_owner = 1'b0;
        exp_raddr = 8'h0; exp_waddr = 8'h0; exp_wdata = 8'h0;
        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h44; addr1 = 8'h55; wdata0 = 8'h0; wdata1 = 8'h0; lock0 = 1'b0; lock1 = 1'b0;

        @(negedge clk); #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;

        // single read, then write followed by read-back through the other requester
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, "rd0");
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "idle0");
        step(1, 1, 8'h20, 8'h33, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, "wr0");
        step(0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, 0, 1, "rd1");
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "idle1");

        // contested reads alternate, last grant was requester 1
        for (int i = 0; i < 6; i++)
            step(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, 0, 0, (i % 2) == 0, (i % 2) == 1, "rr");

        // requester 0 alone, then requester 1 contends with lock asserted
        step(1, 0, 8'h30, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, "pre_lock");
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_LOCK_EN
            step(1, 0, 8'h31, 8'h00, 1, 0, 8'h41, 8'h00, 0, 1, i == 4, i != 4, "lock");
`else
            step(1, 0, 8'h31, 8'h00, 1, 0, 8'h41, 8'h00, 0, 1, (i % 2) == 1, (i % 2) == 0, "lock");
`endif
        end
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "idle2");

        // reset arrives before the granted read can strobe rvalid
        step(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1, 0, "rd_rst");
        #1 rst = 1'b1;
        sb.delete();
        exp_rv = 2'b00; exp_owner = 1'b0;
        exp_raddr = 8'h0; exp_waddr = 8'h0; exp_wdata = 8'h0;
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; #1;
        check_reset_outputs("mid_rst");
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        step(1, 0, 8'h20, 8'h00, 1, 0, 8'h10, 8'h00, 0, 0, 1, 0, "post_rst");
        step(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "idle3");
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
